cnt_seg_scan: RTL and testbench

- Downstream display stage for the team's 5-bit mod-21 counter (range 0..20, advances on the falling edge of `ck`).
- Samples the count on the rising edge of `ck` and converts it to two decimal digits.
- Drives a two-digit multiplexed 7-segment display with leading-zero blanking and inter-digit blanking.
- Flags each counter wrap (20→0) and any illegal input value (>20).

---
 rtl/cnt_seg_scan_pkg.sv | 34 +++
 rtl/cnt_seg_scan_if.sv | 11 +
 rtl/cnt_seg_scan_bcd_to_seg.sv | 14 +
 rtl/cnt_seg_scan.sv | 159 +++++++++++++++
 tb/tb_cnt_seg_scan.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cnt_seg_scan_pkg.sv
// Shared types and constants for the mod-21 count display stage.
// Glyphs are active-high gfedcba; polarity is applied at the top level.
package cnt_seg_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    BLK0 = 2'd1,
    DIG1 = 2'd2,
    BLK1 = 2'd3
  } scan_state_e;

  localparam logic [4:0] MAX_COUNT   = 5'd20;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = GLYPH_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/cnt_seg_scan_if.sv
// Count-in / display-out bundle between the counter side (master) and the scanner (slave).
interface cnt_seg_scan_if;
  logic [4:0] q_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap;
  logic       ovr;

  modport master (output q_in, input seg, input an, input wrap, input ovr);
  modport slave  (input q_in, output seg, output an, output wrap, output ovr);
endinterface

// File: rtl/cnt_seg_scan_bcd_to_seg.sv
// Combinational decimal digit to active-high 7-segment glyph.
module bcd_to_seg
  import cnt_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  // Table lookup; codes above 9 decode to a blank glyph
  always_comb begin
    glyph = digit_glyph(digit);
  end

endmodule

// File: rtl/cnt_seg_scan.sv
// Two-digit multiplexed 7-segment scanner for a mod-21 count, with
// wrap detection and a sticky illegal-input flag.
module cnt_seg_scan
  import cnt_seg_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic           ck,
  input  logic           rs,
  cnt_seg_scan_if.slave  bus
);

  localparam int             DW         = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0]  DWELL_ZERO = DW'(0);
  localparam logic [6:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [4:0]    cnt_r;
  logic [4:0]    prev_r;
  logic          wrap_r;
  logic          ovr_r;
  scan_state_e   state_r;
  logic [DW-1:0] dwell_r;
  logic [6:0]    seg_r;
  logic [1:0]    an_r;

  logic [1:0]    tens_s;
  logic [3:0]    ones_s;
  logic          dwell_done_s;
  logic          lit_tens_s;
  logic          ovr_nx_s;
  logic [3:0]    digit_s;
  logic [6:0]    bcd_glyph_s;
  logic [6:0]    glyph_s;
  logic [6:0]    drive_s;

  // Split the registered count into tens and ones using compares and one subtract
  always_comb begin
    tens_s = 2'd0;
    ones_s = cnt_r[3:0];
    if (cnt_r >= MAX_COUNT) begin
      tens_s = 2'd2;
      ones_s = 4'(cnt_r - MAX_COUNT);
    end else if (cnt_r >= 5'd10) begin
      tens_s = 2'd1;
      ones_s = 4'(cnt_r - 5'd10);
    end else begin
      tens_s = 2'd0;
      ones_s = cnt_r[3:0];
    end
  end

  // Choose the glyph for the state being entered so seg and an load together
  always_comb begin
    dwell_done_s = (dwell_r == DWELL_LAST);
    lit_tens_s   = (state_r == BLK0) || ((state_r == DIG1) && !dwell_done_s);
    ovr_nx_s     = ovr_r || (cnt_r > MAX_COUNT);
    if (lit_tens_s) begin
      digit_s = {2'b00, tens_s};
    end else begin
      digit_s = ones_s;
    end
    if (ovr_nx_s) begin
      glyph_s = GLYPH_DASH;
    end else if (lit_tens_s && (tens_s == 2'd0)) begin
      glyph_s = GLYPH_BLANK;
    end else begin
      glyph_s = bcd_glyph_s;
    end
    if (SEG_ACTIVE_LOW) begin
      drive_s = ~glyph_s;
    end else begin
      drive_s = glyph_s;
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .digit (digit_s),
    .glyph (bcd_glyph_s)
  );

  // Input capture, wrap detection and sticky illegal-value flag
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      cnt_r  <= 5'd0;
      prev_r <= 5'd0;
      wrap_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      cnt_r  <= bus.q_in;
      prev_r <= cnt_r;
      wrap_r <= (prev_r == MAX_COUNT) && (cnt_r == 5'd0);
      ovr_r  <= ovr_nx_s;
    end
  end

  // Scan FSM; reset parks in BLK1 so the first edge lights the ones digit
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state_r <= BLK1;
      dwell_r <= DWELL_ZERO;
      an_r    <= 2'b00;
      seg_r   <= SEG_OFF;
    end else begin
      case (state_r)
        DIG0: begin
          if (dwell_done_s) begin
            state_r <= BLK0;
            dwell_r <= DWELL_ZERO;
            an_r    <= 2'b00;
            seg_r   <= SEG_OFF;
          end else begin
            dwell_r <= dwell_r + DWELL_ONE;
            an_r    <= 2'b01;
            seg_r   <= drive_s;
          end
        end
        BLK0: begin
          state_r <= DIG1;
          dwell_r <= DWELL_ZERO;
          an_r    <= 2'b10;
          seg_r   <= drive_s;
        end
        DIG1: begin
          if (dwell_done_s) begin
            state_r <= BLK1;
            dwell_r <= DWELL_ZERO;
            an_r    <= 2'b00;
            seg_r   <= SEG_OFF;
          end else begin
            dwell_r <= dwell_r + DWELL_ONE;
            an_r    <= 2'b10;
            seg_r   <= drive_s;
          end
        end
        BLK1: begin
          state_r <= DIG0;
          dwell_r <= DWELL_ZERO;
          an_r    <= 2'b01;
          seg_r   <= drive_s;
        end
        default: begin
          state_r <= BLK1;
          dwell_r <= DWELL_ZERO;
          an_r    <= 2'b00;
          seg_r   <= SEG_OFF;
        end
      endcase
    end
  end

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.wrap = wrap_r;
  assign bus.ovr  = ovr_r;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Directed bench: reset/scan vector table plus counter, wrap, illegal-input and reset sequences,
// with a cycle model for two parameterisations.
module tb_cnt_seg_scan;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic ck;
  logic rs;
  int   errors;
  int   checks;
  int   wrap_cnt;

  cnt_seg_scan_if ifa ();
  cnt_seg_scan_if ifb ();

  cnt_seg_scan #(.SCAN_DIV(DIV_A), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .ck  (ck),
    .rs  (rs),
    .bus (ifa)
  );

  cnt_seg_scan #(.SCAN_DIV(DIV_B), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .ck  (ck),
    .rs  (rs),
    .bus (ifb)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int         m_ph   [2];
  logic [4:0] m_cnt  [2];
  logic [4:0] m_prev [2];
  logic       m_ovr  [2];
  logic       m_wrap [2];
  logic [6:0] m_seg  [2];
  logic [1:0] m_an   [2];

  typedef struct {
    logic       rs;
    logic [4:0] qa;
    logic [4:0] qb;
    logic [1:0] an_a;
    logic [6:0] seg_a;
    logic [1:0] an_b;
    logic [6:0] seg_b;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i]   = (i == 0) ? 2 * DIV_A + 1 : 2 * DIV_B + 1;
      m_cnt[i]  = 5'd0;
      m_prev[i] = 5'd0;
      m_ovr[i]  = 1'b0;
      m_wrap[i] = 1'b0;
      m_an[i]   = 2'b00;
      m_seg[i]  = (i == 0) ? 7'h7F : 7'h00;
    end
  endtask

  task automatic model_edge(input logic [4:0] qa, input logic [4:0] qb);
    int d;
    int t;
    int o;
    logic [6:0] g;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? DIV_A : DIV_B;
      m_wrap[i] = (m_prev[i] == 5'd20) && (m_cnt[i] == 5'd0);
      m_ovr[i]  = m_ovr[i] | (m_cnt[i] > 5'd20);
      m_ph[i]   = (m_ph[i] + 1) % (2 * d + 2);
      t = (m_cnt[i] >= 5'd20) ? 2 : ((m_cnt[i] >= 5'd10) ? 1 : 0);
      o = int'(m_cnt[i]) - 10 * t;
      if (m_ph[i] < d) begin
        m_an[i] = 2'b01;
        g = m_ovr[i] ? 7'h40 : ref_glyph(o);
      end else if (m_ph[i] > d && m_ph[i] <= 2 * d) begin
        m_an[i] = 2'b10;
        g = m_ovr[i] ? 7'h40 : ((t == 0) ? 7'h00 : ref_glyph(t));
      end else begin
        m_an[i] = 2'b00;
        g = 7'h00;
      end
      m_seg[i]  = (i == 0) ? ~g : g;
      m_prev[i] = m_cnt[i];
      m_cnt[i]  = (i == 0) ? qa : qb;
    end
  endtask

  task automatic check_all();
    chk("a_seg",  int'(ifa.seg),  int'(m_seg[0]));
    chk("a_an",   int'(ifa.an),   int'(m_an[0]));
    chk("a_wrap", int'(ifa.wrap), int'(m_wrap[0]));
    chk("a_ovr",  int'(ifa.ovr),  int'(m_ovr[0]));
    chk("b_seg",  int'(ifb.seg),  int'(m_seg[1]));
    chk("b_an",   int'(ifb.an),   int'(m_an[1]));
    chk("b_wrap", int'(ifb.wrap), int'(m_wrap[1]));
    chk("b_ovr",  int'(ifb.ovr),  int'(m_ovr[1]));
  endtask

  task automatic tick(input logic r, input logic [4:0] qa, input logic [4:0] qb);
    rs = r;
    ifa.q_in = qa;
    ifb.q_in = qb;
    @(posedge ck);
    #1;
    if (r) model_reset();
    else   model_edge(qa, qb);
    check_all();
    if (ifa.wrap) wrap_cnt++;
  endtask

  task automatic async_reset();
    rs = 1'b1;
    #2;
    model_reset();
    check_all();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    wrap_cnt = 0;
    rs       = 1'b0;
    ifa.q_in = 5'd0;
    ifb.q_in = 5'd12;

    tbl[0]  = '{1'b1, 5'd0, 5'd12, 2'b00, 7'h7F, 2'b00, 7'h00};
    tbl[1]  = '{1'b0, 5'd0, 5'd12, 2'b01, 7'h40, 2'b01, 7'h3F};
    tbl[2]  = '{1'b0, 5'd0, 5'd12, 2'b01, 7'h40, 2'b00, 7'h00};
    tbl[3]  = '{1'b0, 5'd0, 5'd12, 2'b01, 7'h40, 2'b10, 7'h06};
    tbl[4]  = '{1'b0, 5'd0, 5'd12, 2'b01, 7'h40, 2'b00, 7'h00};
    tbl[5]  = '{1'b0, 5'd0, 5'd12, 2'b00, 7'h7F, 2'b01, 7'h5B};
    tbl[6]  = '{1'b0, 5'd0, 5'd12, 2'b10, 7'h7F, 2'b00, 7'h00};
    tbl[7]  = '{1'b0, 5'd0, 5'd12, 2'b10, 7'h7F, 2'b10, 7'h06};
    tbl[8]  = '{1'b0, 5'd0, 5'd12, 2'b10, 7'h7F, 2'b00, 7'h00};
    tbl[9]  = '{1'b0, 5'd0, 5'd12, 2'b10, 7'h7F, 2'b01, 7'h5B};
    tbl[10] = '{1'b0, 5'd0, 5'd12, 2'b00, 7'h7F, 2'b00, 7'h00};
    tbl[11] = '{1'b0, 5'd0, 5'd12, 2'b01, 7'h40, 2'b10, 7'h06};

    #1;
    async_reset();
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].rs, tbl[i].qa, tbl[i].qb);
      chk($sformatf("tbl%0d_an_a", i),  int'(ifa.an),  int'(tbl[i].an_a));
      chk($sformatf("tbl%0d_seg_a", i), int'(ifa.seg), int'(tbl[i].seg_a));
      chk($sformatf("tbl%0d_an_b", i),  int'(ifb.an),  int'(tbl[i].an_b));
      chk($sformatf("tbl%0d_seg_b", i), int'(ifb.seg), int'(tbl[i].seg_b));
    end

    // Real counter sequence through two wraps
    wrap_cnt = 0;
    for (int i = 0; i < 46; i++) tick(1'b0, 5'(i % 21), 5'd12);
    chk("wrap_pulses", wrap_cnt, 2);

    for (int i = 0; i < 12; i++) tick(1'b0, 5'd17, 5'd12);
    for (int i = 0; i < 12; i++) tick(1'b0, 5'd20, 5'd12);

    // Counter reset from 7 must not report a wrap
    wrap_cnt = 0;
    for (int i = 1; i <= 7; i++) tick(1'b0, 5'(i), 5'd12);
    for (int i = 0; i <= 5; i++) tick(1'b0, 5'(i), 5'd12);
    chk("no_wrap_on_clear", wrap_cnt, 0);

    // Illegal input, sticky until reset
    tick(1'b0, 5'd25, 5'd12);
    for (int i = 0; i < 12; i++) tick(1'b0, 5'd3, 5'd12);
    chk("ovr_sticky", int'(ifa.ovr), 1);
    async_reset();
    tick(1'b1, 5'd3, 5'd12);
    for (int i = 0; i < 12; i++) tick(1'b0, 5'd3, 5'd12);

    // Reset in the middle of the tens digit
    for (int i = 0; i < 10 && m_ph[0] != 6; i++) tick(1'b0, 5'd9, 5'd12);
    chk("mid_dig1_an_before", int'(ifa.an), 2);
    async_reset();
    chk("mid_rst_an", int'(ifa.an), 0);
    chk("mid_rst_seg", int'(ifa.seg), 'h7F);
    tick(1'b1, 5'd9, 5'd12);
    tick(1'b0, 5'd9, 5'd12);
    chk("first_lit_ones", int'(ifa.an), 1);
    for (int i = 0; i < 10; i++) tick(1'b0, 5'd9, 5'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
